// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_arbiter.
// slave = arbiter view, master = environment (core units + memory) view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic                  i_read;
  logic [ADDR_W-1:0]     i_address;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [DATA_W/8-1:0]   d_byte_enable;
  logic [ADDR_W-1:0]     d_address;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_resp;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_byte_enable;
  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
    input  mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
    output mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single memory port, one transaction in flight.
// Define MEM_ARBITER_RR_EN for round-robin; default is fixed priority (D beats I).
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]        state;
  logic              cmd_read, cmd_write;
  logic [BE_W-1:0]   cmd_be;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              d_req, d_wins, grant_d, grant_i;

  assign d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARBITER_RR_EN
  // last_i: the previous grant went to I, so D has the next contended slot
  logic last_i;
  assign d_wins = last_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   last_i <= 1'b1;
    else if (state == IDLE && (grant_d || grant_i)) last_i <= grant_i;
  end
`else
  assign d_wins = 1'b1;
`endif

  assign grant_d = d_req && (d_wins || !bus.i_read);
  assign grant_i = bus.i_read && !grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
      cmd_be    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= BUSY_D;
            cmd_addr <= bus.d_address;
            // write takes precedence when both commands are raised
            if (bus.d_write) begin
              cmd_write <= 1'b1;
              cmd_read  <= 1'b0;
              cmd_be    <= bus.d_byte_enable;
              cmd_wdata <= bus.d_wdata;
            end else begin
              cmd_write <= 1'b0;
              cmd_read  <= 1'b1;
              cmd_be    <= '1;
            end
          end else if (grant_i) begin
            state     <= BUSY_I;
            cmd_addr  <= bus.i_address;
            cmd_read  <= 1'b1;
            cmd_write <= 1'b0;
            cmd_be    <= '1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_resp) begin
            state     <= IDLE;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read        = cmd_read;
  assign bus.mem_write       = cmd_write;
  assign bus.mem_byte_enable = cmd_be;
  assign bus.mem_address     = cmd_addr;
  assign bus.mem_wdata       = cmd_wdata;

  assign bus.i_resp  = (state == BUSY_I) && bus.mem_resp;
  assign bus.d_resp  = (state == BUSY_D) && bus.mem_resp;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants queued at stimulus time,
// popped and checked as the memory port issues and completes each command.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_model [int];
  int vectors = 0;
  int miscompares = 0;

  function automatic exp_t mk(bit is_d, bit wr, logic [15:0] addr, logic [1:0] be, logic [15:0] wdata);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.be = be; e.wdata = wdata;
    return e;
  endfunction

  // Serve the next queued transaction: check the command one edge after the
  // request, respond after lat cycles with rd, check routing, then the bubble.
  task automatic serve(input logic [15:0] rd, input int lat);
    exp_t e;
    int   waited;
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard: queue empty, wanted an expected entry");
      return;
    end
    e = exp_q.pop_front();
    @(negedge clk);
    vectors++;
    if ((bus.mem_read | bus.mem_write) !== 1'b1) begin
      miscompares++;
      $display("FAIL grant_latency: no command one edge after request (rd=%b wr=%b)", bus.mem_read, bus.mem_write);
    end
    waited = 0;
    while ((bus.mem_read | bus.mem_write) !== 1'b1 && waited < 10) begin
      @(negedge clk); waited++;
    end
    if (waited == 10) begin
      vectors++; miscompares++;
      $display("FAIL grant_timeout: no command within 10 cycles for addr %h", e.addr);
      return;
    end
    vectors++;
    if ({bus.mem_read, bus.mem_write} !== (e.wr ? 2'b01 : 2'b10)) begin
      miscompares++;
      $display("FAIL cmd %h: got rd/wr %b%b want %b", e.addr, bus.mem_read, bus.mem_write, e.wr ? 2'b01 : 2'b10);
    end
    vectors++;
    if (bus.mem_address !== e.addr || bus.mem_byte_enable !== (e.wr ? e.be : 2'b11)) begin
      miscompares++;
      $display("FAIL addr_be: got %h/%b want %h/%b", bus.mem_address, bus.mem_byte_enable, e.addr, e.wr ? e.be : 2'b11);
    end
    if (e.wr) begin
      vectors++;
      if (bus.mem_wdata !== e.wdata) begin
        miscompares++;
        $display("FAIL wdata: got %h want %h", bus.mem_wdata, e.wdata);
      end
    end
    repeat (lat) @(negedge clk);
    vectors++;
    if (bus.mem_address !== e.addr || bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL hold: got addr %h i_resp %b d_resp %b want %h 0 0", bus.mem_address, bus.i_resp, bus.d_resp, e.addr);
    end
    bus.mem_resp = 1'b1; bus.mem_rdata = rd;
    #1;
    vectors++;
    if (bus.i_resp !== !e.is_d || bus.d_resp !== e.is_d) begin
      miscompares++;
      $display("FAIL resp_route %h: got i_resp %b d_resp %b want %b %b", e.addr, bus.i_resp, bus.d_resp, !e.is_d, e.is_d);
    end
    vectors++;
    if (bus.i_rdata !== rd || bus.d_rdata !== rd) begin
      miscompares++;
      $display("FAIL rdata: got %h/%h want %h", bus.i_rdata, bus.d_rdata, rd);
    end
    if (bus.mem_write) begin
      if (bus.mem_byte_enable[0]) mem_model[int'(bus.mem_address)]     = bus.mem_wdata[7:0];
      if (bus.mem_byte_enable[1]) mem_model[int'(bus.mem_address) + 1] = bus.mem_wdata[15:8];
    end
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    vectors++;
    if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
      miscompares++;
      $display("FAIL bubble: got rd %b wr %b i_resp %b d_resp %b want all 0", bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.mem_read, bus.mem_write, bus.mem_byte_enable} !== 4'b0000 || bus.mem_address !== 16'h0 || bus.mem_wdata !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got rd %b wr %b be %b addr %h wdata %h want zeros", bus.mem_read, bus.mem_write, bus.mem_byte_enable, bus.mem_address, bus.mem_wdata);
    end
    bus.mem_resp = 1'b1; #1;
    vectors++;
    if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_resp: got i_resp %b d_resp %b want 0 0", bus.i_resp, bus.d_resp);
    end
    bus.mem_resp = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    bus.i_read = 1'b1; bus.i_address = 16'h0040;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h0040, 2'b11, 16'h0));
    serve(16'hBEEF, 2);
    bus.i_read = 1'b0;
  endtask

  task automatic test_byte_write();
    bus.d_write = 1'b1; bus.d_address = 16'h0102; bus.d_byte_enable = 2'b10; bus.d_wdata = 16'h12AB;
    exp_q.push_back(mk(1'b1, 1'b1, 16'h0102, 2'b10, 16'h12AB));
    serve(16'h0000, 1);
    bus.d_write = 1'b0;
    vectors++;
    if (!mem_model.exists(32'h103) || mem_model[32'h103] !== 8'h12 || mem_model.exists(32'h102)) begin
      miscompares++;
      $display("FAIL byte_mem: byte 0x103 present %0d value %h, byte 0x102 present %0d; want 12 and 0x102 untouched",
               mem_model.exists(32'h103), mem_model.exists(32'h103) ? mem_model[32'h103] : 8'h00, mem_model.exists(32'h102));
    end
  endtask

  task automatic test_contention();
    do_reset();
    bus.i_read = 1'b1; bus.i_address = 16'h0200;
    bus.d_read = 1'b1; bus.d_address = 16'h0300;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_RR_EN
      if (k % 2 == 0) exp_q.push_back(mk(1'b1, 1'b0, 16'h0300, 2'b11, 16'h0));
      else            exp_q.push_back(mk(1'b0, 1'b0, 16'h0200, 2'b11, 16'h0));
`else
      exp_q.push_back(mk(1'b1, 1'b0, 16'h0300, 2'b11, 16'h0));
`endif
    end
    for (int k = 0; k < 4; k++) serve(16'hA000 + 16'(k), k + 1);
    bus.d_read = 1'b0;
`ifndef MEM_ARBITER_RR_EN
    exp_q.push_back(mk(1'b0, 1'b0, 16'h0200, 2'b11, 16'h0));
    serve(16'hA0FF, 1);
`endif
    bus.i_read = 1'b0;
  endtask

  // An uncontended grant must still move the round-robin pointer.
  task automatic test_rr_pointer();
    do_reset();
    bus.d_read = 1'b1; bus.d_address = 16'h0310;
    exp_q.push_back(mk(1'b1, 1'b0, 16'h0310, 2'b11, 16'h0));
    serve(16'h1111, 1);
    bus.i_read = 1'b1; bus.i_address = 16'h0210;
`ifdef MEM_ARBITER_RR_EN
    exp_q.push_back(mk(1'b0, 1'b0, 16'h0210, 2'b11, 16'h0));
`else
    exp_q.push_back(mk(1'b1, 1'b0, 16'h0310, 2'b11, 16'h0));
`endif
    serve(16'h2222, 1);
    bus.i_read = 1'b0; bus.d_read = 1'b0;
  endtask

  task automatic test_reset_midop();
    bus.d_write = 1'b1; bus.d_address = 16'h0200; bus.d_byte_enable = 2'b11; bus.d_wdata = 16'h5555;
    @(negedge clk);
    vectors++;
    if (bus.mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_start: got mem_write %b want 1", bus.mem_write);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.mem_read, bus.mem_write, bus.mem_byte_enable, bus.d_resp} !== 5'b0 || bus.mem_address !== 16'h0 || bus.mem_wdata !== 16'h0) begin
      miscompares++;
      $display("FAIL async_reset: got wr %b be %b addr %h wdata %h want zeros before clock", bus.mem_write, bus.mem_byte_enable, bus.mem_address, bus.mem_wdata);
    end
    bus.d_write = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus.mem_resp = 1'b1;
    #1;
    vectors++;
    if (bus.d_resp !== 1'b0 || bus.i_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL late_resp: got d_resp %b i_resp %b want 0 0", bus.d_resp, bus.i_resp);
    end
    @(negedge clk); bus.mem_resp = 1'b0;
  endtask

  task automatic test_corner();
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 16'h0010; bus.d_byte_enable = 2'b01; bus.d_wdata = 16'h00CD;
    exp_q.push_back(mk(1'b1, 1'b1, 16'h0010, 2'b01, 16'h00CD));
    serve(16'h0000, 1);
    bus.d_read = 1'b0; bus.d_write = 1'b0;
    @(negedge clk); bus.mem_resp = 1'b1; bus.mem_rdata = 16'h7777;
    #1;
    vectors++;
    if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_resp: got i_resp %b d_resp %b want 0 0", bus.i_resp, bus.d_resp);
    end
    @(negedge clk); bus.mem_resp = 1'b0;
    #1;
    vectors++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_stay: got rd %b wr %b want 0 0", bus.mem_read, bus.mem_write);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_byte_enable = '0; bus.d_address = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    test_reset();
    test_fetch();
    test_byte_write();
    test_corner();
    test_reset_midop();
    test_contention();
    test_rr_pointer();
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL leftover: %0d expected entries never served, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single 16-bit `mem_*` port of the `mp3` core between the instruction-fetch path (read-only) and the data-access path (read/write). Sits between the core's fetch and load/store units and `magic_memory`. Registers the winning request onto the memory port, holds it until `mem_resp`, and routes the response back to the granted requester. One transaction is in flight at a time.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width; byte-enable width is `DATA_W/8`

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_read`  in  1  instruction-fetch read request
- `i_address`  in  ADDR_W  fetch address
- `i_rdata`  out  DATA_W  fetch read data
- `i_resp`  out  1  fetch completion pulse
- `d_read`  in  1  data read request
- `d_write`  in  1  data write request
- `d_byte_enable`  in  DATA_W/8  write byte mask
- `d_address`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  data read data
- `d_resp`  out  1  data completion pulse
- `mem_read`, `mem_write`  out  1  memory command
- `mem_byte_enable`  out  DATA_W/8  memory mask
- `mem_address`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `mem_resp`  in  1  memory completion

## Operation
- States: `IDLE`, `BUSY_I`, `BUSY_D`. Reset state `IDLE`.
- Requester protocol: hold request and its address/data stable until the cycle its `*_resp` is high; deassert by the following edge.
- `IDLE`: on a rising edge with a pending request, pick a winner, latch its fields into the `mem_*` registers, go to `BUSY_I` or `BUSY_D`. No request: stay.
- Grant to I: `mem_read=1`, `mem_write=0`, `mem_byte_enable=2'b11`, `mem_address=i_address`, `mem_wdata` unchanged.
- Grant to D: `d_write=1` drives `mem_write=1`, `mem_read=0`, mask and wdata from D. Otherwise `mem_read=1` with mask `2'b11`. If `d_read` and `d_write` are both high, the write wins.
- `BUSY_x`: `mem_*` registers hold. When `mem_resp=1`, assert `x_resp` combinationally in that cycle. On the next edge return to `IDLE` and clear `mem_read`/`mem_write`.
- `i_rdata` and `d_rdata` are always `mem_rdata` (broadcast). Only the `*_resp` signals are gated.
- `mem_resp` while in `IDLE` is ignored; no `*_resp` is asserted.
- A requester dropping its request mid-transaction is illegal. The arbiter still completes the transaction and pulses that requester's resp.
- Priority on simultaneous requests is set by the configuration macro.

## Timing
- Reset values: `mem_read=0`, `mem_write=0`, `mem_byte_enable=0`, `mem_address=0`, `mem_wdata=0`, `i_resp=0`, `d_resp=0`, state `IDLE`, round-robin pointer = I (last granted I, so D wins first).
- Grant latency: request high at edge N, so `mem_*` command is valid from N+1.
- Response latency: `x_resp` is high in the same cycle as `mem_resp` (zero added latency).
- Minimum one `IDLE` cycle between transactions. Back-to-back requests from the same requester are therefore ≥ 1 bubble apart.
- Reset mid-transaction: all outputs go to reset values asynchronously, and the in-flight transaction is abandoned. A late `mem_resp` after reset release lands in `IDLE` and is dropped.

## Configuration
- `MEM_ARBITER_RR_EN` defined: round-robin arbitration. On a simultaneous request, the requester not granted last wins. The pointer updates on every grant, including uncontended ones.
- Not defined: fixed priority, D always beats I. No pointer register exists.

## Test plan
- Single fetch: `i_read=1`, `i_address=16'h0040`, memory responds 3 cycles later with `16'hBEEF` -> `mem_read=1` and `mem_address=16'h0040` from the next edge. `i_resp=1` and `i_rdata=16'hBEEF` in the `mem_resp` cycle. `d_resp` stays 0.
- Byte write: `d_write=1`, `d_address=16'h0102`, `d_byte_enable=2'b10`, `d_wdata=16'h12AB` -> `mem_write=1`, `mem_read=0`, `mem_byte_enable=2'b10`, `mem_wdata=16'h12AB`. `d_resp` pulses once. Memory byte 0x103 = `8'h12`.
- Contention: `i_read` and `d_read` asserted on the same edge, repeatedly for 4 transactions. With `MEM_ARBITER_RR_EN` -> grant order D, I, D, I. Without it -> D every time, and I waits until D deasserts.
- Reset mid-op: `rst_n` low while in `BUSY_D` with `mem_write=1` -> `mem_write=0` immediately, before the next clock. A late `mem_resp` after release yields no `d_resp`.
- Both-command corner: `d_read=1` and `d_write=1` -> only `mem_write=1`. Spurious `mem_resp` in `IDLE` -> `i_resp=d_resp=0`.
